// File: rtl/seg7_scan_ctrl.sv
// -----------------------------------------------------------------------------
// seg7_scan_ctrl
//
// Multiplexed seven-segment display controller for common-anode digits.
// Digits are scanned one slot at a time. A slot lasts 2^DIGIT_LOG2 clock cycles.
// All display inputs are copied into shadow registers once per frame, on the
// last cycle of the frame. Because the outputs depend only on those shadows,
// a change to the inputs never tears a frame that is already being shown.
//
// Parameters
//   NUM_DIGITS  number of digits scanned (1..16)
//   DIGIT_LOG2  log2 of cycles per digit slot
//   BRIGHT_W    brightness field width (<= DIGIT_LOG2)
//   GUARD       cycles at the start of each slot with all anodes off
//
// Ports
//   clk           system clock
//   rst           asynchronous active-high reset
//   raw_mode_i    0: hex-decode nibbles, 1: raw segment bytes
//   hex_data_i    nibble k drives digit k (digit 0 = bits [3:0])
//   raw_seg_i     byte k = active-high {dp,g,f,e,d,c,b,a} for digit k
//   dp_i          per-digit decimal point (hex mode only)
//   digit_en_i    per-digit enable, 0 blanks the digit
//   brightness_i  PWM duty level, 0 = dimmest, all-ones = full
//   seg_o         registered active-low {dp,g,f,e,d,c,b,a}
//   an_o          registered active-low anode selects, at most one low
//   frame_tick_o  one-cycle pulse in the cycle after the shadows load
// -----------------------------------------------------------------------------
module seg7_scan_ctrl #(
  parameter int NUM_DIGITS = 8,
  parameter int DIGIT_LOG2 = 14,
  parameter int BRIGHT_W   = 4,
  parameter int GUARD      = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    raw_mode_i,
  input  logic [4*NUM_DIGITS-1:0] hex_data_i,
  input  logic [8*NUM_DIGITS-1:0] raw_seg_i,
  input  logic [NUM_DIGITS-1:0]   dp_i,
  input  logic [NUM_DIGITS-1:0]   digit_en_i,
  input  logic [BRIGHT_W-1:0]     brightness_i,
  output logic [7:0]              seg_o,
  output logic [NUM_DIGITS-1:0]   an_o,
  output logic                    frame_tick_o
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [DIGIT_LOG2-1:0] TICK_LAST = {DIGIT_LOG2{1'b1}};
  localparam logic [DIGIT_LOG2-1:0] GUARD_T   = DIGIT_LOG2'(GUARD);
  localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  // Hex nibble to active-low {g,f,e,d,c,b,a}
  function automatic logic [6:0] hex_to_seg7(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'h40;
      4'h1:    seg = 7'h79;
      4'h2:    seg = 7'h24;
      4'h3:    seg = 7'h30;
      4'h4:    seg = 7'h19;
      4'h5:    seg = 7'h12;
      4'h6:    seg = 7'h02;
      4'h7:    seg = 7'h78;
      4'h8:    seg = 7'h00;
      4'h9:    seg = 7'h10;
      4'hA:    seg = 7'h08;
      4'hB:    seg = 7'h03;
      4'hC:    seg = 7'h46;
      4'hD:    seg = 7'h21;
      4'hE:    seg = 7'h06;
      4'hF:    seg = 7'h0E;
      default: seg = 7'h7F;
    endcase
    return seg;
  endfunction

  // Scan state
  logic [DIGIT_LOG2-1:0]   r_tick;
  logic [IDX_W-1:0]        r_idx;

  // Frame shadows
  logic                    r_sh_mode;
  logic [4*NUM_DIGITS-1:0] r_sh_hex;
  logic [8*NUM_DIGITS-1:0] r_sh_raw;
  logic [NUM_DIGITS-1:0]   r_sh_dp;
  logic [NUM_DIGITS-1:0]   r_sh_en;
  logic [BRIGHT_W-1:0]     r_sh_bright;

  // Output registers
  logic [7:0]              r_seg;
  logic [NUM_DIGITS-1:0]   r_an;
  logic                    r_frame_tick;

  // Combinational next-output terms
  logic                    w_slot_end;
  logic                    w_load;
  logic [BRIGHT_W-1:0]     w_phase;
  logic [3:0]              w_nib;
  logic [7:0]              w_raw;
  logic                    w_dp;
  logic                    w_on;
  logic [7:0]              w_seg_val;
  logic [7:0]              w_seg;
  logic [NUM_DIGITS-1:0]   w_an;

  assign w_slot_end = (r_tick == TICK_LAST);
  // The last cycle of the last slot closes the frame, so the shadows load here.
  assign w_load     = w_slot_end && (r_idx == IDX_LAST);
  // The upper tick bits form a slow ramp across the slot. They are compared with the brightness level.
  assign w_phase    = r_tick[DIGIT_LOG2-1 -: BRIGHT_W];

  // Select the current digit's shadow fields and decide whether its anode is on
  always_comb begin
    w_nib = r_sh_hex[{r_idx, 2'b00} +: 4];
    w_raw = r_sh_raw[{r_idx, 3'b000} +: 8];
    w_dp  = r_sh_dp[r_idx];
    // The guard window keeps the old and new anodes from overlapping at a slot boundary.
    w_on  = r_sh_en[r_idx] && (r_tick >= GUARD_T) && (w_phase <= r_sh_bright);
  end

  // Build the segment pattern and the one-cold anode vector for the current slot
  always_comb begin
    w_seg_val = 8'hFF;
    w_seg     = 8'hFF;
    w_an      = {NUM_DIGITS{1'b1}};
    if (r_sh_mode) begin
      w_seg_val = ~w_raw;
    end else begin
      w_seg_val = {~w_dp, hex_to_seg7(w_nib)};
    end
    if (w_on) begin
      w_seg = w_seg_val;
    end else begin
      w_seg = 8'hFF;
    end
    for (int k = 0; k < NUM_DIGITS; k++) begin
      w_an[k] = ~(w_on && (r_idx == IDX_W'(k)));
    end
  end

  // Slot tick and digit index counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tick <= {DIGIT_LOG2{1'b0}};
      r_idx  <= {IDX_W{1'b0}};
    end else begin
      r_tick <= r_tick + {{(DIGIT_LOG2-1){1'b0}}, 1'b1};
      if (w_slot_end) begin
        if (r_idx == IDX_LAST) begin
          r_idx <= {IDX_W{1'b0}};
        end else begin
          r_idx <= r_idx + {{(IDX_W-1){1'b0}}, 1'b1};
        end
      end else begin
        r_idx <= r_idx;
      end
    end
  end

  // Once-per-frame capture of all display inputs into the shadow registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sh_mode   <= 1'b0;
      r_sh_hex    <= {(4*NUM_DIGITS){1'b0}};
      r_sh_raw    <= {(8*NUM_DIGITS){1'b0}};
      r_sh_dp     <= {NUM_DIGITS{1'b0}};
      r_sh_en     <= {NUM_DIGITS{1'b0}};
      r_sh_bright <= {BRIGHT_W{1'b0}};
    end else if (w_load) begin
      r_sh_mode   <= raw_mode_i;
      r_sh_hex    <= hex_data_i;
      r_sh_raw    <= raw_seg_i;
      r_sh_dp     <= dp_i;
      r_sh_en     <= digit_en_i;
      r_sh_bright <= brightness_i;
    end else begin
      r_sh_mode   <= r_sh_mode;
      r_sh_hex    <= r_sh_hex;
      r_sh_raw    <= r_sh_raw;
      r_sh_dp     <= r_sh_dp;
      r_sh_en     <= r_sh_en;
      r_sh_bright <= r_sh_bright;
    end
  end

  // Registered display outputs and frame pulse (one cycle behind the scan state)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_seg        <= 8'hFF;
      r_an         <= {NUM_DIGITS{1'b1}};
      r_frame_tick <= 1'b0;
    end else begin
      r_seg        <= w_seg;
      r_an         <= w_an;
      r_frame_tick <= w_load;
    end
  end

  assign seg_o        = r_seg;
  assign an_o         = r_an;
  assign frame_tick_o = r_frame_tick;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
module tb_seg7_scan_ctrl;

  localparam int N     = 4;
  localparam int DL    = 4;
  localparam int BW    = 2;
  localparam int GD    = 1;
  localparam int SLOT  = 1 << DL;
  localparam int FRAME = N * SLOT;

  logic          clk = 1'b0;
  logic          rst;
  logic          raw_mode_i;
  logic [15:0]   hex_data_i;
  logic [31:0]   raw_seg_i;
  logic [3:0]    dp_i;
  logic [3:0]    digit_en_i;
  logic [1:0]    brightness_i;
  logic [7:0]    seg_o;
  logic [3:0]    an_o;
  logic          frame_tick_o;

  seg7_scan_ctrl #(
    .NUM_DIGITS(N),
    .DIGIT_LOG2(DL),
    .BRIGHT_W(BW),
    .GUARD(GD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .raw_mode_i(raw_mode_i),
    .hex_data_i(hex_data_i),
    .raw_seg_i(raw_seg_i),
    .dp_i(dp_i),
    .digit_en_i(digit_en_i),
    .brightness_i(brightness_i),
    .seg_o(seg_o),
    .an_o(an_o),
    .frame_tick_o(frame_tick_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] seg;
    logic [3:0] an;
    logic       ft;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: cycle number since reset plus the inputs captured at each frame end
  int          cyc;
  logic        m_mode;
  logic [15:0] m_hex;
  logic [31:0] m_raw;
  logic [3:0]  m_dp;
  logic [3:0]  m_en;
  logic [1:0]  m_br;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction

  task automatic model_reset();
    cyc = 0;
    m_mode = 1'b0; m_hex = 16'h0; m_raw = 32'h0;
    m_dp = 4'h0; m_en = 4'h0; m_br = 2'h0;
  endtask

  // Called at each active edge: predicts the outputs registered by that edge
  task automatic model_edge();
    int   pos, dig, tk;
    bit   on;
    exp_t e;
    pos = cyc % FRAME;
    dig = pos / SLOT;
    tk  = pos % SLOT;
    on  = m_en[dig] && (tk >= GD) && ((tk / (SLOT >> BW)) <= int'(m_br));
    if (on) begin
      if (m_mode) e.seg = ~m_raw[dig*8 +: 8];
      else        e.seg = {~m_dp[dig], hex7(m_hex[dig*4 +: 4])};
      e.an = 4'hF;
      e.an[dig] = 1'b0;
    end else begin
      e.seg = 8'hFF;
      e.an  = 4'hF;
    end
    e.ft = (pos == FRAME - 1);
    if (e.ft) begin
      m_mode = raw_mode_i; m_hex = hex_data_i; m_raw = raw_seg_i;
      m_dp = dp_i; m_en = digit_en_i; m_br = brightness_i;
    end
    q.push_back(e);
    cyc++;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic rand_inputs();
    raw_mode_i   = 1'($urandom_range(0, 1));
    hex_data_i   = 16'($urandom);
    raw_seg_i    = $urandom;
    dp_i         = 4'($urandom);
    digit_en_i   = 4'($urandom);
    brightness_i = 2'($urandom);
  endtask

  task automatic check_reset_vals(input string tag);
    checks++;
    if (seg_o !== 8'hFF || an_o !== 4'hF || frame_tick_o !== 1'b0) begin
      errors++;
      $display("FAIL %s: got seg=%h an=%h ft=%b, expected seg=ff an=f ft=0",
               tag, seg_o, an_o, frame_tick_o);
    end
  endtask

  // Monitor: pops one expected output per cycle and compares away from the active edge
  always @(negedge clk) begin
    exp_t e;
    if (!rst && q.size() > 0) begin
      e = q.pop_front();
      checks++;
      if (seg_o !== e.seg || an_o !== e.an || frame_tick_o !== e.ft) begin
        errors++;
        $display("FAIL scan @%0t: got seg=%h an=%h ft=%b, expected seg=%h an=%h ft=%b",
                 $time, seg_o, an_o, frame_tick_o, e.seg, e.an, e.ft);
      end
    end
  end

  initial begin
    rst = 1'b1;
    raw_mode_i = 1'b0; hex_data_i = 16'h0000; raw_seg_i = 32'h0;
    dp_i = 4'h0; digit_en_i = 4'hF; brightness_i = 2'd3;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset_init");
    rst = 1'b0;

    // Frame 0 is blank; new data is set mid-frame and loads at its end
    repeat (20) step();
    hex_data_i = 16'hF810; dp_i = 4'b0100;
    repeat (FRAME - 20 + 2 * FRAME) step();

    // Brightness levels
    brightness_i = 2'd1;
    repeat (2 * FRAME) step();
    brightness_i = 2'd0;
    repeat (2 * FRAME) step();

    // Disabled digits 0 and 2
    brightness_i = 2'd3; digit_en_i = 4'b1010;
    repeat (2 * FRAME) step();

    // Raw mode, then a hex change mid-frame that must stay invisible until the next load
    digit_en_i = 4'hF; raw_mode_i = 1'b1; raw_seg_i = 32'h5A3C_1880;
    repeat (FRAME + 30) step();
    hex_data_i = 16'h1234; raw_mode_i = 1'b0;
    repeat (2 * FRAME) step();

    // Randomized inputs, changing at arbitrary points within frames
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 7) == 0) rand_inputs();
      step();
    end

    // Inputs changed exactly in the load cycle are captured
    for (int r = 0; r < 4; r++) begin
      while ((cyc % FRAME) != FRAME - 1) step();
      rand_inputs();
      digit_en_i = 4'hF;
      repeat (FRAME + 5) step();
    end

    // Reset asserted at tick 9 of digit 2, with that digit lit
    raw_mode_i = 1'b0; digit_en_i = 4'hF; brightness_i = 2'd3; hex_data_i = 16'($urandom);
    do step(); while ((cyc % FRAME) != 0);
    while ((cyc % FRAME) != 2 * SLOT + 9) step();
    #2;
    rst = 1'b1;
    #1;
    check_reset_vals("reset_midframe");
    q.delete();
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("reset_held");
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 3 * FRAME; i++) begin
      if ($urandom_range(0, 15) == 0) rand_inputs();
      step();
    end

    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, expected 0", q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
